// File: rtl/run_detect_scheduler.sv
// -----------------------------------------------------------------------------
// run_detect_scheduler
//
// Purpose:
//   Shares one serial run-length detector between NUM_CH bit-stream
//   requesters. A round-robin arbiter picks one requesting channel per cycle.
//   The granted channel's sample bit is applied to that channel's saved run
//   count:
//     - a 1 extends the run, saturating at RUN_LEN;
//     - a 0 clears the run.
//   detect[ch] is high while the run equals RUN_LEN. A flush request clears
//   the run state one channel per cycle. Every detect rising edge is reported
//   as a single-cycle event and counted by a saturating counter.
//
// Ports:
//   clk          in   1        clock
//   reset        in   1        synchronous, active-high reset (highest priority)
//   enable       in   1        1 = arbitrate/service requests, 0 = hold state
//   flush        in   1        one-cycle pulse, starts a channel-by-channel clear
//   req          in   NUM_CH   per-channel sample request (level)
//   bit_in       in   NUM_CH   per-channel sample bit, valid while req is set
//   grant        out  NUM_CH   one-hot; channel whose sample was consumed last cycle
//   detect       out  NUM_CH   per-channel detect level
//   event_ch     out  CH_W     channel of the most recent detect rising edge
//   event_pulse  out  1        one-cycle pulse, cycle after a detect rising edge
//   event_count  out  CNT_W    saturating count of detect rising edges
//   busy         out  1        high while flushing
// -----------------------------------------------------------------------------
module run_detect_scheduler #(
    parameter int NUM_CH  = 4,
    parameter int RUN_LEN = 2,
    parameter int CNT_W   = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      flush,
    input  logic [NUM_CH-1:0]         req,
    input  logic [NUM_CH-1:0]         bit_in,
    output logic [NUM_CH-1:0]         grant,
    output logic [NUM_CH-1:0]         detect,
    output logic [$clog2(NUM_CH)-1:0] event_ch,
    output logic                      event_pulse,
    output logic [CNT_W-1:0]          event_count,
    output logic                      busy
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int RUN_W = $clog2(RUN_LEN + 1);

    localparam logic [RUN_W-1:0]  RUN_MAX = RUN_W'(RUN_LEN);
    localparam logic [CH_W-1:0]   LAST_CH = CH_W'(NUM_CH - 1);
    localparam logic [NUM_CH-1:0] ONE_HOT_0 = NUM_CH'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t              r_state;
    logic [CH_W-1:0]     r_rr;           // first channel looked at next search
    logic [CH_W-1:0]     r_flush_idx;    // channel cleared this FLUSH cycle
    logic [NUM_CH-1:0]   r_grant;
    logic [NUM_CH-1:0]   r_detect;
    logic [NUM_CH-1:0]   r_detect_d;     // detect one cycle late, for edge finding
    logic                r_event_pulse;
    logic [CH_W-1:0]     r_event_ch;
    logic [CNT_W-1:0]    r_event_count;

    // -------------------------------------------------------------------------
    // Combinational signals
    // -------------------------------------------------------------------------
    state_t              w_state_next;
    logic                w_arb_en;       // a grant may be issued at this edge
    logic                w_flush_clr;    // clear channel r_flush_idx at this edge
    logic                w_grant_valid;
    logic [CH_W-1:0]     w_grant_ch;
    logic                w_grant_fire;
    logic [CH_W-1:0]     w_rr_next;
    logic [CH_W-1:0]     w_flush_idx_next;
    logic [NUM_CH-1:0]   w_rise;
    logic                w_rise_any;
    logic [CH_W-1:0]     w_rise_ch;

    // -------------------------------------------------------------------------
    // FSM: next state and per-state enables
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_arb_en     = 1'b0;
        w_flush_clr  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (flush) begin
                    w_state_next = ST_FLUSH;
                end else if (enable) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                // flush wins over enable; a flush cycle issues no grant
                if (flush) begin
                    w_state_next = ST_FLUSH;
                end else if (!enable) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_arb_en = 1'b1;
                end
            end
            ST_FLUSH: begin
                // flush pulses arriving here are deliberately ignored
                w_flush_clr = 1'b1;
                if (r_flush_idx == LAST_CH) begin
                    w_state_next = enable ? ST_RUN : ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Round-robin search starting at r_rr. Walking offsets from high to low
    // leaves the lowest requesting offset as the final winner.
    // -------------------------------------------------------------------------
    always_comb begin
        logic [CH_W-1:0] w_idx;
        int              k;
        w_grant_valid = 1'b0;
        w_grant_ch    = '0;
        w_idx         = '0;
        k             = 0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            k = int'(r_rr) + i;
            if (k >= NUM_CH) begin
                k = k - NUM_CH;
            end
            w_idx = CH_W'(k);
            if (req[w_idx]) begin
                w_grant_valid = 1'b1;
                w_grant_ch    = w_idx;
            end
        end
    end

    assign w_grant_fire = w_arb_en && w_grant_valid;
    assign w_rr_next    = (w_grant_ch == LAST_CH) ? '0 : w_grant_ch + 1'b1;
    assign w_flush_idx_next = (r_flush_idx == LAST_CH) ? '0 : r_flush_idx + 1'b1;

    // grant, pointer and flush index
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant     <= '0;
            r_rr        <= '0;
            r_flush_idx <= '0;
        end else begin
            r_grant <= w_grant_fire ? (ONE_HOT_0 << w_grant_ch) : '0;
            if (w_grant_fire) begin
                r_rr <= w_rr_next;
            end
            // the index parks at 0 outside FLUSH so each flush starts at ch0
            r_flush_idx <= w_flush_clr ? w_flush_idx_next : '0;
        end
    end

    // -------------------------------------------------------------------------
    // Per-channel run state. Each channel owns its run counter and detect bit;
    // only the granted channel (or the channel being flushed) changes.
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [RUN_W-1:0] r_run;
        logic             r_det;
        logic [RUN_W-1:0] w_run_inc;
        logic             w_clear;
        logic             w_serve;

        assign w_run_inc = (r_run == RUN_MAX) ? RUN_MAX : r_run + 1'b1;
        assign w_clear   = w_flush_clr && (r_flush_idx == CH_W'(gi));
        assign w_serve   = w_grant_fire && (w_grant_ch == CH_W'(gi));

        always_ff @(posedge clk) begin
            if (reset) begin
                r_run <= '0;
                r_det <= 1'b0;
            end else if (w_clear) begin
                r_run <= '0;
                r_det <= 1'b0;
            end else if (w_serve) begin
                if (bit_in[gi]) begin
                    r_run <= w_run_inc;
                    r_det <= (w_run_inc == RUN_MAX);
                end else begin
                    r_run <= '0;
                    r_det <= 1'b0;
                end
            end
        end

        assign r_detect[gi] = r_det;
    end

    // -------------------------------------------------------------------------
    // Event reporting. grant is one-hot, so at most one detect bit can rise
    // per cycle; the priority encoder below never has to pick between two.
    // -------------------------------------------------------------------------
    assign w_rise     = r_detect & ~r_detect_d;
    assign w_rise_any = |w_rise;

    always_comb begin
        w_rise_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_rise[i]) begin
                w_rise_ch = CH_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_detect_d    <= '0;
            r_event_pulse <= 1'b0;
            r_event_ch    <= '0;
            r_event_count <= '0;
        end else begin
            r_detect_d    <= r_detect;
            r_event_pulse <= w_rise_any;
            if (w_rise_any) begin
                r_event_ch <= w_rise_ch;
                if (r_event_count != {CNT_W{1'b1}}) begin
                    r_event_count <= r_event_count + 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign grant       = r_grant;
    assign detect      = r_detect;
    assign event_ch    = r_event_ch;
    assign event_pulse = r_event_pulse;
    assign event_count = r_event_count;
    assign busy        = (r_state == ST_FLUSH);

endmodule

// File: tb/tb_run_detect_scheduler.sv
// -----------------------------------------------------------------------------
// tb_run_detect_scheduler
//
// Self-checking bench for run_detect_scheduler. Two instances share the same
// inputs: the default configuration and one with a 2-bit event counter. A
// cycle-level reference model tracks every channel's run length, the
// round-robin pointer, the flush progress and pending events.
// -----------------------------------------------------------------------------
module tb_run_detect_scheduler;

    localparam int NUM_CH  = 4;
    localparam int RUN_LEN = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic              flush;
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] bit_in;

    logic [NUM_CH-1:0] grant, detect;
    logic [1:0]        event_ch;
    logic              event_pulse;
    logic [7:0]        event_count;
    logic              busy;

    logic [NUM_CH-1:0] grant_s, detect_s;
    logic [1:0]        event_ch_s;
    logic              event_pulse_s;
    logic [1:0]        event_count_s;
    logic              busy_s;

    int n_checks = 0;
    int n_fails  = 0;
    int n_txn    = 0;

    always #5 clk = ~clk;

    run_detect_scheduler #(.NUM_CH(NUM_CH), .RUN_LEN(RUN_LEN), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .enable(enable), .flush(flush),
        .req(req), .bit_in(bit_in), .grant(grant), .detect(detect),
        .event_ch(event_ch), .event_pulse(event_pulse),
        .event_count(event_count), .busy(busy)
    );

    run_detect_scheduler #(.NUM_CH(NUM_CH), .RUN_LEN(RUN_LEN), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .enable(enable), .flush(flush),
        .req(req), .bit_in(bit_in), .grant(grant_s), .detect(detect_s),
        .event_ch(event_ch_s), .event_pulse(event_pulse_s),
        .event_count(event_count_s), .busy(busy_s)
    );

    // ---------------------------------------------------------------------
    // Reference model
    // ---------------------------------------------------------------------
    int   m_run [NUM_CH];
    bit   m_det [NUM_CH];
    int   m_rr;
    int   m_mode;        // 0 idle, 1 servicing, 2 flushing
    int   m_fidx;
    bit   m_pend;
    int   m_pend_ch;
    int   m_count;
    int   m_count2;

    logic [NUM_CH-1:0] exp_grant, exp_detect;
    logic              exp_pulse, exp_busy;
    logic [1:0]        exp_ch;

    task automatic model_edge();
        bit found;
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_run[c] = 0;
                m_det[c] = 0;
            end
            m_rr = 0; m_mode = 0; m_fidx = 0; m_pend = 0; m_pend_ch = 0;
            m_count = 0; m_count2 = 0;
            exp_grant = '0; exp_pulse = 0; exp_ch = '0;
        end else begin
            exp_pulse = m_pend;
            if (m_pend) begin
                exp_ch = 2'(m_pend_ch);
                if (m_count < 255) m_count++;
                if (m_count2 < 3) m_count2++;
            end
            m_pend    = 0;
            exp_grant = '0;
            if (m_mode == 2) begin
                m_run[m_fidx] = 0;
                m_det[m_fidx] = 0;
                m_fidx++;
                if (m_fidx == NUM_CH) m_mode = enable ? 1 : 0;
            end else if (flush) begin
                m_mode = 2;
                m_fidx = 0;
            end else if (m_mode == 0) begin
                if (enable) m_mode = 1;
            end else if (!enable) begin
                m_mode = 0;
            end else begin
                found = 0;
                for (int off = 0; off < NUM_CH; off++) begin
                    int c;
                    c = (m_rr + off) % NUM_CH;
                    if (!found && req[c]) begin
                        found = 1;
                        exp_grant[c] = 1'b1;
                        if (bit_in[c]) begin
                            bit was;
                            was = m_det[c];
                            m_run[c] = (m_run[c] + 1 > RUN_LEN) ? RUN_LEN : m_run[c] + 1;
                            m_det[c] = (m_run[c] == RUN_LEN);
                            if (!was && m_det[c]) begin
                                m_pend    = 1;
                                m_pend_ch = c;
                            end
                        end else begin
                            m_run[c] = 0;
                            m_det[c] = 0;
                        end
                        m_rr = (c + 1) % NUM_CH;
                    end
                end
            end
        end
        for (int c = 0; c < NUM_CH; c++) exp_detect[c] = m_det[c];
        exp_busy = (m_mode == 2);
    endtask

    // One clock: inputs already driven by the caller are sampled at the edge,
    // the model advances, and outputs are read 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        n_txn++;
        $display("txn %0d: rst=%b en=%b fl=%b req=%b bit=%b -> grant=%b detect=%b busy=%b ev=%b ch=%0d cnt=%0d cnt2=%0d",
                 n_txn, reset, enable, flush, req, bit_in, grant, detect, busy,
                 event_pulse, event_ch, event_count, event_count_s);
    endtask

    task automatic do_reset();
        reset = 1; enable = 0; flush = 0; req = '0; bit_in = '0;
        step();
        reset = 0;
    endtask

    // ---------------------------------------------------------------------
    // Scenarios
    // ---------------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        step();
        if ({grant, detect, event_pulse, event_ch, busy} !== '0) begin
            n_fails++;
            $display("FAIL reset_outputs: got grant=%b detect=%b ev=%b ch=%0d busy=%b, expected all 0",
                     grant, detect, event_pulse, event_ch, busy);
        end
        n_checks++;
        if (event_count !== 8'd0 || event_count_s !== 2'd0) begin
            n_fails++;
            $display("FAIL reset_count: got %0d/%0d expected 0/0", event_count, event_count_s);
        end
        n_checks++;
    endtask

    task automatic test_single_channel();
        logic [3:0] bits     = 4'b0111;   // bit k applied on grant k: 1,1,1,0
        logic [3:0] want_det = 4'b0110;   // detect[0] after grant k: 0,1,1,0
        int pulses = 0;
        do_reset();
        enable = 1;
        step();
        for (int k = 0; k < 4; k++) begin
            req = 4'b0001; bit_in = {3'b000, bits[k]};
            step();
            pulses += int'(event_pulse);
            if (grant !== 4'b0001) begin
                n_fails++;
                $display("FAIL single_grant[%0d]: got %b expected 0001", k, grant);
            end
            n_checks++;
            if (detect[0] !== want_det[k] || detect !== exp_detect) begin
                n_fails++;
                $display("FAIL single_detect[%0d]: got %b expected %b", k, detect, exp_detect);
            end
            n_checks++;
        end
        req = '0; bit_in = '0;
        step();
        pulses += int'(event_pulse);
        if (pulses != 1 || event_ch !== 2'd0 || event_count !== 8'd1) begin
            n_fails++;
            $display("FAIL single_event: got pulses=%0d ch=%0d cnt=%0d expected 1/0/1",
                     pulses, event_ch, event_count);
        end
        n_checks++;
    endtask

    task automatic test_round_robin();
        do_reset();
        enable = 1;
        step();
        req = 4'b1111; bit_in = 4'b0100;
        for (int k = 0; k < 8; k++) begin
            logic [3:0] want;
            want = 4'b0001 << (k % 4);
            step();
            if (grant !== want || grant !== exp_grant) begin
                n_fails++;
                $display("FAIL rr_grant[%0d]: got %b expected %b", k, grant, want);
            end
            n_checks++;
            if (detect !== exp_detect) begin
                n_fails++;
                $display("FAIL rr_detect[%0d]: got %b expected %b", k, detect, exp_detect);
            end
            n_checks++;
        end
        if (detect !== 4'b0100) begin
            n_fails++;
            $display("FAIL rr_final_detect: got %b expected 0100", detect);
        end
        n_checks++;
    endtask

    task automatic test_interleave();
        do_reset();
        enable = 1;
        step();
        req = 4'b0001; bit_in = 4'b0001; step();
        req = 4'b0010; bit_in = 4'b0000; step();
        if (grant !== 4'b0010) begin
            n_fails++;
            $display("FAIL inter_grant1a: got %b expected 0010", grant);
        end
        n_checks++;
        step();
        if (grant !== 4'b0010 || detect !== 4'b0000) begin
            n_fails++;
            $display("FAIL inter_grant1b: got grant=%b detect=%b expected 0010/0000", grant, detect);
        end
        n_checks++;
        req = 4'b0001; bit_in = 4'b0001; step();
        if (grant !== 4'b0001 || detect !== 4'b0001) begin
            n_fails++;
            $display("FAIL inter_ch0_rise: got grant=%b detect=%b expected 0001/0001", grant, detect);
        end
        n_checks++;
    endtask

    task automatic test_flush();
        int busy_cycles = 0;
        do_reset();
        enable = 1;
        step();
        req = 4'b1111; bit_in = 4'b1111;
        repeat (8) step();
        req = '0; step();                  // lets the last event land
        if (detect !== 4'b1111 || event_count !== 8'd4) begin
            n_fails++;
            $display("FAIL flush_pre: got detect=%b cnt=%0d expected 1111/4", detect, event_count);
        end
        n_checks++;
        req = 4'b1111; flush = 1;
        step();
        busy_cycles += int'(busy);
        flush = 0;
        for (int k = 0; k < 4; k++) begin
            if (grant !== 4'b0000 || busy !== exp_busy || detect !== exp_detect) begin
                n_fails++;
                $display("FAIL flush_cycle[%0d]: got grant=%b busy=%b detect=%b expected 0000/%b/%b",
                         k, grant, busy, detect, exp_busy, exp_detect);
            end
            n_checks++;
            step();
            busy_cycles += int'(busy);
        end
        if (busy_cycles != 4 || detect !== 4'b0000 || event_count !== 8'd4 || busy !== 1'b0) begin
            n_fails++;
            $display("FAIL flush_done: got busy_cycles=%0d detect=%b cnt=%0d busy=%b expected 4/0000/4/0",
                     busy_cycles, detect, event_count, busy);
        end
        n_checks++;
        step();
        if (grant !== 4'b0001) begin
            n_fails++;
            $display("FAIL flush_resume: got %b expected 0001", grant);
        end
        n_checks++;
    endtask

    task automatic test_saturation();
        int want_cnt [5] = '{1, 2, 3, 3, 3};
        int seen = 0;
        do_reset();
        enable = 1;
        step();
        for (int k = 0; k < 17; k++) begin
            req    = (k < 15) ? 4'b0001 : 4'b0000;
            bit_in = (k % 3 == 2) ? 4'b0000 : 4'b0001;
            step();
            if (event_pulse_s) begin
                if (seen < 5 && event_count_s !== 2'(want_cnt[seen])) begin
                    n_fails++;
                    $display("FAIL sat_count[%0d]: got %0d expected %0d", seen, event_count_s, want_cnt[seen]);
                end
                n_checks++;
                seen++;
            end
        end
        if (seen != 5 || event_count !== 8'd5 || event_count_s !== 2'd3) begin
            n_fails++;
            $display("FAIL sat_total: got events=%0d cnt=%0d cnt2=%0d expected 5/5/3",
                     seen, event_count, event_count_s);
        end
        n_checks++;
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        enable = 1;
        step();
        req = 4'b1111; bit_in = 4'b1111;
        repeat (8) step();
        flush = 1; step();
        flush = 0; step();
        if (busy !== 1'b1) begin
            n_fails++;
            $display("FAIL rmf_busy: got %b expected 1", busy);
        end
        n_checks++;
        reset = 1; step();
        if ({grant, detect, event_pulse, event_ch, busy} !== '0 || event_count !== 8'd0) begin
            n_fails++;
            $display("FAIL rmf_cleared: got grant=%b detect=%b ev=%b ch=%0d busy=%b cnt=%0d expected all 0",
                     grant, detect, event_pulse, event_ch, busy, event_count);
        end
        n_checks++;
        reset = 0; step();
        if (grant !== 4'b0000 || busy !== 1'b0) begin
            n_fails++;
            $display("FAIL rmf_idle: got grant=%b busy=%b expected 0000/0", grant, busy);
        end
        n_checks++;
        step();
        if (grant !== 4'b0001) begin
            n_fails++;
            $display("FAIL rmf_restart: got %b expected 0001", grant);
        end
        n_checks++;
    endtask

    task automatic test_enable_toggle();
        do_reset();
        enable = 1;
        step();
        req = 4'b0010; bit_in = 4'b0010;
        repeat (2) step();
        enable = 0; req = 4'b1111; bit_in = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            step();
            if (grant !== 4'b0000 || detect !== 4'b0010) begin
                n_fails++;
                $display("FAIL en_hold[%0d]: got grant=%b detect=%b expected 0000/0010", k, grant, detect);
            end
            n_checks++;
        end
        enable = 1;
        step();
        step();
        if (grant !== 4'b0100) begin
            n_fails++;
            $display("FAIL en_resume: got %b expected 0100", grant);
        end
        n_checks++;
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            reset  = ($urandom_range(0, 199) == 0);
            enable = ($urandom_range(0, 7) != 0);
            flush  = ($urandom_range(0, 24) == 0);
            req    = 4'($urandom);
            bit_in = 4'($urandom) | 4'($urandom);
            step();
            if (grant !== exp_grant || detect !== exp_detect || busy !== exp_busy) begin
                n_fails++;
                $display("FAIL rand_state[%0d]: got grant=%b detect=%b busy=%b expected %b/%b/%b",
                         k, grant, detect, busy, exp_grant, exp_detect, exp_busy);
            end
            n_checks++;
            if (event_pulse !== exp_pulse || event_ch !== exp_ch ||
                event_count !== 8'(m_count) || event_count_s !== 2'(m_count2)) begin
                n_fails++;
                $display("FAIL rand_event[%0d]: got ev=%b ch=%0d cnt=%0d cnt2=%0d expected %b/%0d/%0d/%0d",
                         k, event_pulse, event_ch, event_count, event_count_s,
                         exp_pulse, exp_ch, m_count, m_count2);
            end
            n_checks++;
        end
        reset = 0; flush = 0;
    endtask

    initial begin
        reset = 1; enable = 0; flush = 0; req = '0; bit_in = '0;
        test_reset();
        test_single_channel();
        test_round_robin();
        test_interleave();
        test_flush();
        test_saturation();
        test_reset_mid_flush();
        test_enable_toggle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
